// File: rtl/retry_pkg.sv
// Shared definitions for the retry loop (entry and end): ID parity check and item disposition.
package retry_pkg;

  localparam int MinIDSize = 2;
  localparam int MaxIDSize = 32;

  typedef enum logic [1:0] {
    ITEM_IDLE,
    ITEM_FWD,
    ITEM_RETRY,
    ITEM_DROP
  } item_disp_e;

  // IDs carry even parity: XOR over all bits (MSB parity included) must be 0.
  // Zero-extension to MaxIDSize leaves the XOR unchanged.
  function automatic logic id_parity_ok(input logic [MaxIDSize-1:0] id);
    return ~(^id);
  endfunction

  function automatic item_disp_e classify(input logic accept, input logic needs_retry,
                                          input logic parity_ok);
    item_disp_e d;
    d = ITEM_IDLE;
    if (accept) begin
      if (!needs_retry)   d = ITEM_FWD;
      else if (parity_ok) d = ITEM_RETRY;
      else                d = ITEM_DROP;
    end
    return d;
  endfunction

endpackage

// File: rtl/retry_end_fifo.sv
// Failed-ID queue: in-order FIFO with wrapping pointers (any depth) and a registered head entry.
module retry_end_fifo #(
  parameter int Width = 2,
  parameter int Depth = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [Width-1:0] push_data_i,
  input  logic             pop_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [Width-1:0] head_o
);

  localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int CntW = $clog2(Depth + 1);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  rd_ptr_q, wr_ptr_q, rd_ptr_nxt;
  logic [CntW-1:0]  count_q;
  logic [Width-1:0] head_q, head_d;
  logic             push_eff, pop_eff;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty_o    = (count_q == '0);
  assign full_o     = (count_q == CntW'(Depth));
  assign push_eff   = push_i & ~full_o;
  assign pop_eff    = pop_i & ~empty_o;
  assign rd_ptr_nxt = ptr_inc(rd_ptr_q);
  assign head_o     = head_q;

  // Head is precomputed so the retry ID comes straight from a register.
  always_comb begin
    head_d = head_q;
    if (pop_eff) begin
      if (count_q > CntW'(1)) head_d = mem_q[rd_ptr_nxt];
      else if (push_eff)      head_d = push_data_i;
    end else if (empty_o && push_eff) begin
      head_d = push_data_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
    end else begin
      head_q <= head_d;
      if (push_eff) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop_eff)  rd_ptr_q <= rd_ptr_nxt;
      count_q <= count_q + CntW'(push_eff) - CntW'(pop_eff);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_eff) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/retry_end.sv
// Tail of the time-redundant retry loop: forwards clean items, queues failed IDs for replay.
// Optional statistics counters are built when RETRY_END_STATS_EN is defined.
module retry_end
  import retry_pkg::*;
#(
  parameter type DataType   = logic,
  parameter int  IDSize     = 2,
  parameter int  RetryDepth = 2
`ifdef RETRY_END_STATS_EN
  ,
  parameter int  StatWidth  = 16
`endif
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  DataType           data_i,
  input  logic [IDSize-1:0] id_i,
  input  logic              needs_retry_i,
  input  logic              valid_i,
  output logic              ready_o,
  output DataType           data_o,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [IDSize-1:0] retry_id_o,
  output logic              retry_valid_o,
  input  logic              retry_ready_i,
  output logic              id_error_o
`ifdef RETRY_END_STATS_EN
  ,
  output logic [StatWidth-1:0] retry_count_o,
  output logic [StatWidth-1:0] id_error_count_o
`endif
);

  // Handshakes: a transfer happens on a cycle where valid and ready are both high;
  // valid never depends on ready, and the retry port's ready never reaches ready_o.
  logic       q_full, q_empty, parity_ok, accept, push, pop, id_error_q;
  item_disp_e disp;

  assign parity_ok = id_parity_ok(MaxIDSize'(id_i));
  assign valid_o   = valid_i & ~needs_retry_i;
  assign data_o    = data_i;
  assign ready_o   = needs_retry_i ? ~q_full : ready_i;
  assign accept    = valid_i & ready_o;
  assign disp      = classify(accept, needs_retry_i, parity_ok);
  assign push      = (disp == ITEM_RETRY);

  assign retry_valid_o = ~q_empty;
  assign pop           = retry_valid_o & retry_ready_i;
  assign id_error_o    = id_error_q;

  retry_end_fifo #(
    .Width (IDSize),
    .Depth (RetryDepth)
  ) u_fifo (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .push_i      (push),
    .push_data_i (id_i),
    .pop_i       (pop),
    .full_o      (q_full),
    .empty_o     (q_empty),
    .head_o      (retry_id_o)
  );

  // Parity is flagged on any accepted item, clean ones included.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) id_error_q <= 1'b0;
    else         id_error_q <= accept & ~parity_ok;
  end

`ifdef RETRY_END_STATS_EN
  logic [StatWidth-1:0] retry_cnt_q, err_cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      retry_cnt_q <= '0;
      err_cnt_q   <= '0;
    end else begin
      if (pop && (retry_cnt_q != '1))      retry_cnt_q <= retry_cnt_q + 1'b1;
      if (id_error_q && (err_cnt_q != '1)) err_cnt_q   <= err_cnt_q + 1'b1;
    end
  end

  assign retry_count_o    = retry_cnt_q;
  assign id_error_count_o = err_cnt_q;
`endif

endmodule
